// File: rtl/ast_pkt_rr_arbiter_if.sv
// Avalon-ST bundle between N_SRC packet sources, the packet round-robin arbiter
// and the downstream width converter. The arbiter takes the slave view.
interface ast_pkt_rr_arbiter_if #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 10,
  parameter int SRC_W     = 2
);
  logic [N_SRC*DATA_W-1:0]    ast_data_i;
  logic [N_SRC-1:0]           ast_startofpacket_i;
  logic [N_SRC-1:0]           ast_endofpacket_i;
  logic [N_SRC-1:0]           ast_valid_i;
  logic [N_SRC*EMPTY_W-1:0]   ast_empty_i;
  logic [N_SRC*CHANNEL_W-1:0] ast_channel_i;
  logic [N_SRC-1:0]           ast_ready_o;
  logic [DATA_W-1:0]          ast_data_o;
  logic                       ast_startofpacket_o;
  logic                       ast_endofpacket_o;
  logic                       ast_valid_o;
  logic [EMPTY_W-1:0]         ast_empty_o;
  logic [CHANNEL_W-1:0]       ast_channel_o;
  logic [SRC_W-1:0]           ast_src_o;
  logic                       ast_ready_i;

  modport slave (
    input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
    input  ast_empty_i, ast_channel_i, ast_ready_i,
    output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
    output ast_valid_o, ast_empty_o, ast_channel_o, ast_src_o
  );

  modport master (
    output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
    output ast_empty_i, ast_channel_i, ast_ready_i,
    input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
    input  ast_valid_o, ast_empty_o, ast_channel_o, ast_src_o
  );
endinterface

// File: rtl/ast_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: one source owns the output from its first
// beat through eop, feeding a single registered output stage with backpressure.
module ast_pkt_rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 10,
  parameter int SRC_W     = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  ast_pkt_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                 state_r;
  logic [SRC_W-1:0]       grant_r;
  logic [SRC_W-1:0]       rr_ptr_r;

  logic                   valid_r;
  logic [DATA_W-1:0]      data_r;
  logic                   sop_r;
  logic                   eop_r;
  logic [EMPTY_W-1:0]     empty_r;
  logic [CHANNEL_W-1:0]   channel_r;
  logic [SRC_W-1:0]       src_r;

  logic [DATA_W-1:0]      data_arr_s    [N_SRC];
  logic [EMPTY_W-1:0]     empty_arr_s   [N_SRC];
  logic [CHANNEL_W-1:0]   channel_arr_s [N_SRC];

  logic [DATA_W-1:0]      g_data_s;
  logic [EMPTY_W-1:0]     g_empty_s;
  logic [CHANNEL_W-1:0]   g_channel_s;
  logic                   g_valid_s;
  logic                   g_sop_s;
  logic                   g_eop_s;

  logic [SRC_W-1:0]       sel_s;
  logic                   any_valid_s;
  int                     sel_idx_s;
  logic                   sel_hit_s;
  logic [SRC_W-1:0]       next_ptr_s;
  logic                   load_en_s;
  logic                   accept_s;
  logic [N_SRC-1:0]       ready_s;

  // Split the packed per-source lanes so the granted lane can be picked by index.
  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      data_arr_s[k]    = bus.ast_data_i[k*DATA_W +: DATA_W];
      empty_arr_s[k]   = bus.ast_empty_i[k*EMPTY_W +: EMPTY_W];
      channel_arr_s[k] = bus.ast_channel_i[k*CHANNEL_W +: CHANNEL_W];
    end
  end

  // Fields of the currently granted source.
  always_comb begin
    g_data_s    = data_arr_s[grant_r];
    g_empty_s   = empty_arr_s[grant_r];
    g_channel_s = channel_arr_s[grant_r];
    g_valid_s   = bus.ast_valid_i[grant_r];
    g_sop_s     = bus.ast_startofpacket_i[grant_r];
    g_eop_s     = bus.ast_endofpacket_i[grant_r];
  end

  // First valid source at or above the round-robin pointer, wrapping modulo N_SRC.
  always_comb begin
    sel_s       = '0;
    any_valid_s = 1'b0;
    sel_idx_s   = 0;
    sel_hit_s   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_idx_s   = (int'(rr_ptr_r) + i) % N_SRC;
      sel_hit_s   = bus.ast_valid_i[sel_idx_s] & ~any_valid_s;
      sel_s       = sel_hit_s ? SRC_W'(sel_idx_s) : sel_s;
      any_valid_s = any_valid_s | bus.ast_valid_i[sel_idx_s];
    end
  end

  // Handshake terms; ready has no path from any source valid.
  always_comb begin
    next_ptr_s = (grant_r == SRC_W'(N_SRC - 1)) ? SRC_W'(0) : grant_r + SRC_W'(1);
    load_en_s  = ~valid_r | bus.ast_ready_i;
    accept_s   = (state_r == LOCK) & g_valid_s & load_en_s;
    for (int k = 0; k < N_SRC; k++) begin
      ready_s[k] = (state_r == LOCK) && (grant_r == SRC_W'(k)) && load_en_s;
    end
  end

  // Arbitration FSM plus the output register stage it feeds.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      rr_ptr_r  <= '0;
      valid_r   <= 1'b0;
      data_r    <= '0;
      sop_r     <= 1'b0;
      eop_r     <= 1'b0;
      empty_r   <= '0;
      channel_r <= '0;
      src_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          // Granting costs one bubble: nothing is accepted in this state.
          if (any_valid_s) begin
            grant_r <= sel_s;
            state_r <= LOCK;
          end
        end
        LOCK: begin
          if (accept_s && g_eop_s) begin
            rr_ptr_r <= next_ptr_s;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (accept_s) begin
        valid_r   <= 1'b1;
        data_r    <= g_data_s;
        sop_r     <= g_sop_s;
        eop_r     <= g_eop_s;
        empty_r   <= g_empty_s;
        channel_r <= g_channel_s;
        src_r     <= grant_r;
      end else if (bus.ast_ready_i) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.ast_ready_o         = ready_s;
  assign bus.ast_valid_o         = valid_r;
  assign bus.ast_data_o          = data_r;
  assign bus.ast_startofpacket_o = sop_r;
  assign bus.ast_endofpacket_o   = eop_r;
  assign bus.ast_empty_o         = empty_r;
  assign bus.ast_channel_o       = channel_r;
  assign bus.ast_src_o           = src_r;

endmodule

// File: tb/tb_ast_pkt_rr_arbiter.sv
// Self-checking bench for ast_pkt_rr_arbiter: a directed vector table, hand-written
// corner sequences and randomized traffic checked against a packet-level model.
module tb_ast_pkt_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 10;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic arst;

  ast_pkt_rr_arbiter_if #(.N_SRC(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW), .SRC_W(SW)) bus ();

  ast_pkt_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW), .SRC_W(SW)) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [CW-1:0] ch;
    logic [EW-1:0] emp;
    logic          eop;
    logic          sop;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [2:0] emp;
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic       osop;
    logic       oeop;
    logic [2:0] oemp;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the output, where the next search starts, and the
  // beat (if any) that should be sitting in the output register.
  int      owner;
  int      ptr;
  beat_t   pipe[$];
  logic [N-1:0] acc;
  int      order_q[$];
  int      out_beats;

  // Source generators
  bit            active[N];
  int            len[N];
  int            idx[N];
  int            gap[N];
  logic [DW-1:0] base[N];
  logic [CW-1:0] chn[N];
  logic [EW-1:0] emp[N];
  bit            rnd_drop_en;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t dut_beat();
    beat_t b;
    b.src  = bus.ast_src_o;
    b.ch   = bus.ast_channel_o;
    b.emp  = bus.ast_empty_o;
    b.eop  = bus.ast_endofpacket_o;
    b.sop  = bus.ast_startofpacket_o;
    b.data = bus.ast_data_o;
    return b;
  endfunction

  function automatic logic [31:0] order_code();
    logic [23:0] v;
    v = 24'h0;
    foreach (order_q[i]) v = (v << 4) | 24'(order_q[i]);
    return {8'(order_q.size()), v};
  endfunction

  function automatic bit busy();
    bit b;
    b = (pipe.size() != 0) || (owner >= 0);
    for (int k = 0; k < N; k++) b = b || active[k];
    return b;
  endfunction

  task automatic model_reset();
    owner = -1;
    ptr   = 0;
    pipe.delete();
    acc   = '0;
    for (int k = 0; k < N; k++) begin
      active[k] = 1'b0;
      gap[k]    = 0;
    end
  endtask

  // Check DUT outputs against the model, then advance the model over the next edge.
  task automatic model_step();
    bit           le;
    logic [N-1:0] er;
    beat_t        b;
    le = (pipe.size() == 0) || bus.ast_ready_i;
    er = '0;
    for (int k = 0; k < N; k++) if (owner == k && le) er[k] = 1'b1;
    chk("ready_o", 128'(bus.ast_ready_o), 128'(er));
    chk("valid_o", 128'(bus.ast_valid_o), 128'(pipe.size() != 0));
    if (pipe.size() != 0) chk("out_beat", 128'(dut_beat()), 128'(pipe[0]));
    if (bus.ast_valid_o && bus.ast_ready_i) begin
      out_beats++;
      if (bus.ast_startofpacket_o) order_q.push_back(int'(bus.ast_src_o));
    end
    acc = '0;
    if (pipe.size() != 0 && bus.ast_ready_i) void'(pipe.pop_front());
    if (owner >= 0) begin
      if (bus.ast_valid_i[owner] && le) begin
        acc[owner] = 1'b1;
        b.src  = SW'(owner);
        b.ch   = bus.ast_channel_i[owner*CW +: CW];
        b.emp  = bus.ast_empty_i[owner*EW +: EW];
        b.eop  = bus.ast_endofpacket_i[owner];
        b.sop  = bus.ast_startofpacket_i[owner];
        b.data = bus.ast_data_i[owner*DW +: DW];
        pipe.push_back(b);
        if (b.eop) begin
          ptr   = (owner + 1) % N;
          owner = -1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (owner < 0 && bus.ast_valid_i[(ptr + i) % N]) owner = (ptr + i) % N;
    end
  endtask

  task automatic start_pkt(input int k, input int l, input logic [DW-1:0] b,
                           input logic [CW-1:0] c, input logic [EW-1:0] e);
    active[k] = 1'b1;
    len[k]    = l;
    idx[k]    = 0;
    base[k]   = b;
    chn[k]    = c;
    emp[k]    = e;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      logic v;
      logic last;
      v = active[k] && (gap[k] == 0);
      if (rnd_drop_en && $urandom_range(3) == 0) v = 1'b0;
      last = (idx[k] == len[k] - 1);
      bus.ast_valid_i[k]              = v;
      bus.ast_data_i[k*DW +: DW]      = base[k] + DW'(idx[k]);
      bus.ast_startofpacket_i[k]      = (idx[k] == 0);
      bus.ast_endofpacket_i[k]        = last;
      bus.ast_empty_i[k*EW +: EW]     = last ? emp[k] : EW'(0);
      bus.ast_channel_i[k*CW +: CW]   = chn[k];
    end
  endtask

  // One clock: drive after the edge, check/advance at the falling edge.
  task automatic cycle();
    drive();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        idx[k]++;
        if (idx[k] == len[k]) active[k] = 1'b0;
      end
      if (gap[k] > 0) gap[k]--;
    end
  endtask

  task automatic run_quiet(input string name, input int budget);
    int i;
    i = 0;
    while (busy() && i < budget) begin
      cycle();
      i++;
    end
    chk({name, "_timeout"}, 128'(i < budget), 128'(1));
  endtask

  // Reset asserted mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    arst = 1'b1;
    #1;
    chk("rst_valid_o", 128'(bus.ast_valid_o), 128'(0));
    chk("rst_outputs", 128'({bus.ast_ready_o, dut_beat()}), 128'(0));
    model_reset();
    bus.ast_valid_i = '0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   n;
    tbl[0] = '{1'b1, 8'hA0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 8'hA0, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 8'hA1, 1'b0, 1'b0, 3'd0, 4'b0100, 1'b1, 8'hA0, 1'b1, 1'b0, 3'd0};
    tbl[3] = '{1'b1, 8'hA2, 1'b0, 1'b1, 3'd5, 4'b0100, 1'b1, 8'hA1, 1'b0, 1'b0, 3'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1, 8'hA2, 1'b0, 1'b1, 3'd5};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};

    arst            = 1'b1;
    rnd_drop_en     = 1'b0;
    out_beats       = 0;
    bus.ast_valid_i = '0;
    bus.ast_data_i  = '0;
    bus.ast_startofpacket_i = '0;
    bus.ast_endofpacket_i   = '0;
    bus.ast_empty_i   = '0;
    bus.ast_channel_i = '0;
    bus.ast_ready_i   = 1'b1;
    for (int k = 0; k < N; k++) begin
      len[k] = 1; idx[k] = 0; base[k] = '0; chn[k] = '0; emp[k] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_outputs", 128'({bus.ast_valid_o, bus.ast_ready_o, dut_beat()}), 128'(0));
    arst = 1'b0;

    // Idle after reset
    repeat (4) cycle();

    // Contention: every source holds a 2-beat packet
    for (int k = 0; k < N; k++) start_pkt(k, 2, DW'(64'h1000 * (k + 1)), CW'(k + 1), EW'(k));
    order_q.delete();
    run_quiet("contention", 60);
    chk("contention_order", 128'(order_code()), 128'({8'd4, 24'h000123}));

    // Directed vectors: src2 alone, 3-beat packet on channel 7
    bus.ast_valid_i   = '0;
    bus.ast_channel_i = '0;
    bus.ast_empty_i   = '0;
    bus.ast_channel_i[2*CW +: CW] = 10'd7;
    for (int i = 0; i < 6; i++) begin
      beat_t eb;
      bus.ast_valid_i[2]            = tbl[i].v;
      bus.ast_data_i[2*DW +: DW]    = DW'(tbl[i].d);
      bus.ast_startofpacket_i[2]    = tbl[i].sop;
      bus.ast_endofpacket_i[2]      = tbl[i].eop;
      bus.ast_empty_i[2*EW +: EW]   = tbl[i].emp;
      @(negedge clk);
      eb = '{src: 2'd2, ch: 10'd7, emp: tbl[i].oemp, eop: tbl[i].oeop, sop: tbl[i].osop, data: DW'(tbl[i].od)};
      chk($sformatf("tbl%0d_ready", i), 128'(bus.ast_ready_o), 128'(tbl[i].rdy));
      chk($sformatf("tbl%0d_valid", i), 128'(bus.ast_valid_o), 128'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_beat", i), 128'(dut_beat()), 128'(eb));
      model_step();
      @(posedge clk);
      #1;
    end

    // Backpressure during src1's 4-beat packet: ready_i 1,0,0,1,0,0,...
    out_beats = 0;
    start_pkt(1, 4, 64'hB100, 10'd3, 3'd2);
    n = 0;
    while (busy() && n < 80) begin
      bus.ast_ready_i = (n % 3 == 0);
      cycle();
      n++;
    end
    chk("bp_timeout", 128'(n < 80), 128'(1));
    chk("bp_beats", 128'(out_beats), 128'(4));
    bus.ast_ready_i = 1'b1;

    // Rotation and wrap with single-beat packets
    order_q.delete();
    start_pkt(3, 1, 64'hC300, 10'd1, 3'd1);
    run_quiet("rot_a", 20);
    start_pkt(3, 1, 64'hC310, 10'd1, 3'd1);
    start_pkt(0, 1, 64'hC000, 10'd2, 3'd3);
    run_quiet("rot_b", 20);
    start_pkt(3, 1, 64'hC320, 10'd1, 3'd4);
    n = 0;
    while (!bus.ast_valid_o && n < 10) begin
      cycle();
      n++;
    end
    chk("regrant_latency", 128'(n), 128'(2));
    run_quiet("rot_c", 20);
    chk("rotation_order", 128'(order_code()), 128'({8'd4, 24'h003033}));

    // src0 stalls mid-packet while src1 waits, then reset during src1's packet
    start_pkt(0, 3, 64'hD000, 10'd5, 3'd6);
    start_pkt(1, 2, 64'hD100, 10'd6, 3'd7);
    n = 0;
    while (idx[0] < 1 && n < 10) begin
      cycle();
      n++;
    end
    chk("stall_first_beat", 128'(idx[0]), 128'(1));
    gap[0] = 5;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_src1_blocked", 128'(bus.ast_ready_o[1]), 128'(0));
    end
    n = 0;
    while (active[0] && n < 20) begin
      cycle();
      n++;
    end
    chk("stall_src0_done", 128'(active[0]), 128'(0));
    n = 0;
    while (idx[1] < 1 && n < 10) begin
      cycle();
      n++;
    end
    chk("src1_started", 128'(idx[1]), 128'(1));
    do_reset();
    order_q.delete();
    start_pkt(1, 1, 64'hE100, 10'd8, 3'd0);
    start_pkt(0, 1, 64'hE000, 10'd9, 3'd0);
    run_quiet("post_reset", 20);
    chk("post_reset_order", 128'(order_code()), 128'({8'd2, 24'h000001}));

    // Randomized traffic against the model
    rnd_drop_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.ast_ready_i = ($urandom_range(3) != 0);
      for (int k = 0; k < N; k++)
        if (!active[k] && $urandom_range(7) == 0)
          start_pkt(k, int'($urandom_range(5, 1)), {$urandom, $urandom}, CW'($urandom), EW'($urandom));
      cycle();
    end
    rnd_drop_en = 1'b0;
    bus.ast_ready_i = 1'b1;
    run_quiet("random_drain", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
